mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data (load/store) port of the multicycle CPU.
- Accepts one request at a time and holds address, write data and write enable stable for the whole access.
- Counts the memory latency, captures read data and returns a one-cycle done pulse to the winning requester.
- Sits between the multicycle control/datapath and the memory model; replaces the control unit's hard-coded IF1-IF4 / MEM1-MEM4 wait states with a req/done handshake.

Parameters:
- LATENCY, 4, memory access cycles per transaction; legal range 1..15.
- DATA_PRIO, 1, 1 = data port wins simultaneous requests; 0 = round-robin (the port not served last wins).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  32  fetch byte address.
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  32  fetched word, registered.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse: data access complete, d_rdata valid (loads).
- d_rdata  out  32  loaded word, registered.
- mem_addr  out  32  memory address, registered at grant.
- mem_wdata  out  32  memory write data, registered at grant.
- mem_re  out  1  high for every BUSY cycle of a load or fetch.
- mem_we  out  1  high only in the last BUSY cycle of a store.
- mem_rdata  in  32  memory read data, valid in the last BUSY cycle.
- busy  out  1  high in BUSY and RESP.

Behaviour:
- States: IDLE, BUSY, RESP. Owner register: 0 = fetch, 1 = data. Down-counter cnt, 4 bits.
- Reset (async, reset==0): state=IDLE; cnt=0; owner=0; last_served=0; all outputs 0, including i_rdata and d_rdata.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's addr, wdata and we into mem_addr, mem_wdata and an internal we_r; set owner; cnt=LATENCY-1; go to BUSY.
  - Fetch grants drive mem_wdata=0 and we_r=0.
- Arbitration (IDLE only):
  - Single request: that port wins.
  - Both requesting, DATA_PRIO=1: data wins.
  - Both requesting, DATA_PRIO=0: the port with last_served != port wins; last_served updates on each grant.
- BUSY:
  - Lasts exactly LATENCY cycles.
  - mem_addr and mem_wdata are held constant.
  - mem_re = !we_r for every BUSY cycle.
  - mem_we = we_r && (cnt==0).
  - cnt decrements each cycle. When cnt==0: if !we_r, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Exactly one cycle: the owner's done output is 1 and the other done stays 0.
  - Unconditionally returns to IDLE. Requests are not sampled in RESP.
- Timing:
  - Request first seen high at edge E puts the block in BUSY from E to E+LATENCY; done is high in the cycle after edge E+LATENCY.
  - Back-to-back throughput is one transaction per LATENCY+2 cycles.
- rdata registers hold their value until the next completed read for that port. Stores leave d_rdata unchanged.
- Request changes after grant:
  - Dropped request: the access still completes and done still pulses. A store is never aborted.
  - Changed address or data: ignored until the next grant.
- A losing request stays pending and is granted at the next IDLE. The loser's done stays 0 meanwhile.
- Reset asserted mid-BUSY: abort immediately; mem_we and mem_re go to 0 asynchronously; no done pulse is issued.
- LATENCY=1: BUSY lasts one cycle, with cnt==0 on entry.

Test Plan:
- Fetch only, LATENCY=4: i_req=1 with i_addr=0x10 and mem returning 0x00500093 -> mem_re high 4 cycles with mem_addr=0x10, mem_we=0; i_done pulses once in cycle 5 after grant; i_rdata=0x00500093.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we high only in the 4th BUSY cycle; mem_re=0 throughout; d_done pulses once; d_rdata unchanged.
- Simultaneous i_req and d_req, DATA_PRIO=1 -> data served first; i_done only after the second transaction; total 12 cycles for both.
- Round-robin, DATA_PRIO=0, both ports held high for 4 transactions -> grant order alternates D,I,D,I when last_served=fetch after reset.
- Reset asserted during BUSY cycle 2 of a store -> mem_we never goes high; no done pulse; IDLE with all outputs 0; a new fetch after reset release completes normally.
- LATENCY=1 load, d_addr=0x8, mem returning 0x1234 -> done 2 cycles after grant edge; d_rdata=0x1234; busy high exactly 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified memory.
// The arbiter takes the slave view; the CPU/memory side takes the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data ports,
// one transaction at a time, with a req/done handshake towards the multicycle CPU.
module mem_port_arbiter #(
  parameter int LATENCY   = 4,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_lastServed;
  logic        r_we;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [31:0] r_iRdata;
  logic [31:0] r_dRdata;

  logic w_anyReq;
  logic w_grantData;
  logic w_cntZero;

  // Data wins when alone, under fixed priority, or when fetch was served last.
  always_comb begin
    w_anyReq    = bus.i_req | bus.d_req;
    w_grantData = bus.d_req & (~bus.i_req | DATA_PRIO | ~r_lastServed);
    w_cntZero   = (r_cnt == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_lastServed <= 1'b0;
      r_we         <= 1'b0;
      r_memAddr    <= 32'd0;
      r_memWdata   <= 32'd0;
      r_iRdata     <= 32'd0;
      r_dRdata     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner      <= w_grantData;
            r_lastServed <= w_grantData;
            r_memAddr    <= w_grantData ? bus.d_addr : bus.i_addr;
            r_memWdata   <= w_grantData ? bus.d_wdata : 32'd0;
            r_we         <= w_grantData & bus.d_we;
            r_cnt        <= CNT_INIT;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_cntZero) begin
            if (!r_we) begin
              if (r_owner) r_dRdata <= bus.mem_rdata;
              else         r_iRdata <= bus.mem_rdata;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so reset removes them without waiting for a clock.
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_re    = (r_state == BUSY) & ~r_we;
  assign bus.mem_we    = (r_state == BUSY) & r_we & w_cntZero;
  assign bus.i_done    = (r_state == RESP) & ~r_owner;
  assign bus.d_done    = (r_state == RESP) & r_owner;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.i_rdata   = r_iRdata;
  assign bus.d_rdata   = r_dRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: three arbiters (priority/L=4, round-robin/L=4, priority/L=1)
// share one clock and reset; a monitor pops expected transactions as done pulses.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tStart = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if ifA();
  mem_port_arbiter_if ifB();
  mem_port_arbiter_if ifC();

  mem_port_arbiter #(.LATENCY(4), .DATA_PRIO(1'b1)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  mem_port_arbiter #(.LATENCY(4), .DATA_PRIO(1'b0)) dutB (.clk(clk), .reset(reset), .bus(ifB));
  mem_port_arbiter #(.LATENCY(1), .DATA_PRIO(1'b1)) dutC (.clk(clk), .reset(reset), .bus(ifC));

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h10)     return 32'h0050_0093;
    else if (a == 32'h8) return 32'h0000_1234;
    else                 return a ^ 32'hC0DE_0000;
  endfunction

  assign ifA.mem_rdata = memData(ifA.mem_addr);
  assign ifB.mem_rdata = memData(ifB.mem_addr);
  assign ifC.mem_rdata = memData(ifC.mem_addr);

  typedef struct {
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sbA[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Queues the expected transaction on dut A and raises the matching request.
  task automatic applyStimulus(input bit isData, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    txn_t t;
    t.isData = isData;
    t.we     = we;
    t.addr   = addr;
    t.wdata  = isData ? wdata : 32'd0;
    t.rdata  = we ? 32'd0 : memData(addr);
    sbA.push_back(t);
    tStart = cyc;
    if (isData) begin
      ifA.d_req = 1'b1; ifA.d_we = we; ifA.d_addr = addr; ifA.d_wdata = wdata;
    end else begin
      ifA.i_req = 1'b1; ifA.i_addr = addr;
    end
  endtask

  task automatic waitDone(input bit isData, output int lat);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      seen = isData ? ifA.d_done : ifA.i_done;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    lat = cyc - tStart;
  endtask

  // Per-transaction monitor for dut A: strobe counts, held bus values, done/rdata.
  initial begin
    int  busyCnt = 0, reCnt = 0, weCnt = 0, weAt = 0;
    bit  addrBad = 1'b0, wdBad = 1'b0;
    txn_t f;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busyCnt = 0; reCnt = 0; weCnt = 0; weAt = 0; addrBad = 1'b0; wdBad = 1'b0;
      end else begin
        if (ifA.busy) begin
          busyCnt++;
          if (ifA.mem_re) reCnt++;
          if (ifA.mem_we) begin weCnt++; weAt = busyCnt; end
          if (sbA.size() == 0) addrBad = 1'b1;
          else begin
            if (ifA.mem_addr !== sbA[0].addr) addrBad = 1'b1;
            if (ifA.mem_we && ifA.mem_wdata !== sbA[0].wdata) wdBad = 1'b1;
          end
        end
        if (ifA.i_done || ifA.d_done) begin
          if (sbA.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            f = sbA.pop_front();
            checkOutput("done_port", 32'(ifA.d_done), 32'(f.isData));
            checkOutput("both_done", 32'(ifA.i_done & ifA.d_done), 32'd0);
            checkOutput("busy_len", 32'(busyCnt), 32'd5);
            checkOutput("addr_hold", 32'(addrBad), 32'd0);
            if (f.we) begin
              checkOutput("we_cycles", 32'(weCnt), 32'd1);
              checkOutput("we_pos", 32'(weAt), 32'd4);
              checkOutput("re_in_store", 32'(reCnt), 32'd0);
              checkOutput("wdata_hold", 32'(wdBad), 32'd0);
            end else begin
              checkOutput("re_cycles", 32'(reCnt), 32'd4);
              checkOutput("we_in_read", 32'(weCnt), 32'd0);
              checkOutput("rdata", f.isData ? ifA.d_rdata : ifA.i_rdata, f.rdata);
            end
          end
          busyCnt = 0; reCnt = 0; weCnt = 0; weAt = 0; addrBad = 1'b0; wdBad = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bc;
    int rc;
    bit seen;
    foreach (ifA.i_addr[b]) begin end
    ifA.i_req = 0; ifA.i_addr = 0; ifA.d_req = 0; ifA.d_we = 0; ifA.d_addr = 0; ifA.d_wdata = 0;
    ifB.i_req = 0; ifB.i_addr = 0; ifB.d_req = 0; ifB.d_we = 0; ifB.d_addr = 0; ifB.d_wdata = 0;
    ifC.i_req = 0; ifC.i_addr = 0; ifC.d_req = 0; ifC.d_we = 0; ifC.d_addr = 0; ifC.d_wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(ifA.busy), 32'd0);
    checkOutput("rst_mem_re", 32'(ifA.mem_re), 32'd0);
    checkOutput("rst_mem_we", 32'(ifA.mem_we), 32'd0);
    checkOutput("rst_done", 32'({ifA.i_done, ifA.d_done}), 32'd0);
    checkOutput("rst_mem_addr", ifA.mem_addr, 32'd0);
    checkOutput("rst_i_rdata", ifA.i_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;

    // Single fetch.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'd0);
    waitDone(1'b0, lat);
    ifA.i_req = 0;
    checkOutput("fetch_lat", 32'(lat), 32'd5);

    // Load then store on the data port; store must leave d_rdata alone.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
    waitDone(1'b1, lat);
    ifA.d_req = 0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    waitDone(1'b1, lat);
    ifA.d_req = 0;
    checkOutput("store_lat", 32'(lat), 32'd5);
    checkOutput("store_keeps_drdata", ifA.d_rdata, 32'hC0DE_0040);

    // Simultaneous requests: data first, fetch waits a full turn.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h44, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h48, 32'd0);
    waitDone(1'b1, lat);
    ifA.d_req = 0;
    checkOutput("dual_first_lat", 32'(lat), 32'd5);
    waitDone(1'b0, lat);
    ifA.i_req = 0;
    checkOutput("dual_total_cycles", 32'(lat + 1), 32'd12);

    // Store whose request drops and whose bus changes right after grant.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 32'h104, 32'h1234_5678);
    @(posedge clk); #1;
    ifA.d_req = 0; ifA.d_addr = 32'h999; ifA.d_wdata = 32'h0;
    waitDone(1'b1, lat);
    checkOutput("dropped_store_lat", 32'(lat), 32'd5);

    // Fetch whose address changes mid-access.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'h50, 32'd0);
    @(posedge clk); #1;
    ifA.i_addr = 32'h60;
    waitDone(1'b0, lat);
    ifA.i_req = 0;

    // Reset in the second BUSY cycle of a store aborts it with no done pulse.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    sbA.delete();
    #1;
    checkOutput("abort_mem_we", 32'(ifA.mem_we), 32'd0);
    checkOutput("abort_mem_re", 32'(ifA.mem_re), 32'd0);
    checkOutput("abort_busy", 32'(ifA.busy), 32'd0);
    checkOutput("abort_done", 32'({ifA.i_done, ifA.d_done}), 32'd0);
    checkOutput("abort_d_rdata", ifA.d_rdata, 32'd0);
    checkOutput("abort_mem_addr", ifA.mem_addr, 32'd0);
    ifA.d_req = 0;
    repeat (2) @(negedge clk);
    checkOutput("abort_mem_we_held", 32'(ifA.mem_we), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'd0);
    waitDone(1'b0, lat);
    ifA.i_req = 0;
    checkOutput("post_reset_fetch_lat", 32'(lat), 32'd5);

    // Round-robin: both held, last_served=fetch after reset, so D,I,D,I.
    @(posedge clk); #1;
    ifB.i_req = 1; ifB.i_addr = 32'h20; ifB.d_req = 1; ifB.d_we = 0; ifB.d_addr = 32'h30;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        seen = ifB.i_done | ifB.d_done;
      end
      checkOutput("rr_seen", 32'(seen), 32'd1);
      checkOutput("rr_port", 32'(ifB.d_done), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_both_done", 32'(ifB.i_done & ifB.d_done), 32'd0);
      if (ifB.d_done) checkOutput("rr_d_rdata", ifB.d_rdata, 32'hC0DE_0030);
      else            checkOutput("rr_i_rdata", ifB.i_rdata, 32'hC0DE_0020);
    end
    ifB.i_req = 0; ifB.d_req = 0;

    // LATENCY=1 load.
    @(posedge clk); #1;
    tStart = cyc;
    ifC.d_req = 1; ifC.d_we = 0; ifC.d_addr = 32'h8;
    bc = 0; rc = 0; seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (ifC.busy) bc++;
      if (ifC.mem_re) rc++;
      seen = ifC.d_done;
    end
    ifC.d_req = 0;
    checkOutput("l1_seen", 32'(seen), 32'd1);
    checkOutput("l1_lat", 32'(cyc - tStart), 32'd2);
    checkOutput("l1_rdata", ifC.d_rdata, 32'h0000_1234);
    checkOutput("l1_busy_cycles", 32'(bc), 32'd2);
    checkOutput("l1_re_cycles", 32'(rc), 32'd1);
    @(negedge clk);
    checkOutput("l1_idle_after", 32'(ifC.busy), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbA.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
